// File: rtl/adpcm_pkg.sv
// Shared types and defaults for the ADPCM filtez multiply-accumulate engine.
package adpcm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DefNtaps = 6;
  localparam int unsigned DefShift = 14;
  localparam int unsigned DefAccW  = 35;

  // Half an output LSB, added before the shift for round-half-up.
  function automatic logic [63:0] round_const(input int unsigned shift);
    return 64'(1) << (shift - 1);
  endfunction

  localparam logic [63:0] DefRoundConst = round_const(DefShift);

endpackage

// File: rtl/adpcm_filtez_mul.sv
// Combinational full-precision signed multiplier for the filtez MAC.
module adpcm_filtez_mul #(
  parameter int unsigned COEF_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic signed [COEF_W-1:0]        a_i,
  input  logic signed [DATA_W-1:0]        b_i,
  output logic signed [COEF_W+DATA_W-1:0] p_o
);

  assign p_o = (COEF_W + DATA_W)'(a_i) * (COEF_W + DATA_W)'(b_i);

endmodule

// File: rtl/adpcm_filtez_mac.sv
// Six-tap sequential MAC for the ADPCM zero-section predictor: sum(bpl*dlt) >>> SHIFT.
// Define ADPCM_FILTEZ_ROUND_EN to round half-up instead of truncating toward -inf.
module adpcm_filtez_mac
  import adpcm_pkg::*;
#(
  parameter int unsigned NTAPS  = DefNtaps,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned SHIFT  = DefShift,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] bpl_address0,
  output logic              bpl_ce0,
  input  logic [COEF_W-1:0] bpl_q0,
  output logic [ADDR_W-1:0] dlt_address0,
  output logic              dlt_ce0,
  input  logic [DATA_W-1:0] dlt_q0,
  output logic [OUT_W-1:0]  ap_return
);

  state_e                          state_q, state_d;
  logic [ADDR_W-1:0]               k_q, k_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic                            acc_valid_q, acc_valid_d;
  logic [OUT_W-1:0]                ret_q, ret_d;
  logic signed [COEF_W+DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_rnd;
  logic signed [ACC_W-1:0]         acc_shr;
  logic                            accum;

  adpcm_filtez_mul #(
    .COEF_W(COEF_W),
    .DATA_W(DATA_W)
  ) u_mul (
    .a_i(bpl_q0),
    .b_i(dlt_q0),
    .p_o(prod)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    acc_valid_d = acc_valid_q;
    ret_d       = ret_q;
    accum       = 1'b0;
    acc_rnd     = '0;
    acc_shr     = '0;

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          state_d     = StRun;
          k_d         = '0;
          acc_valid_d = 1'b0;
        end
      end
      StRun: begin
        // Memory data lags the address by one cycle, so tap k-1 arrives now.
        accum = (k_q != '0);
        if (k_q == ADDR_W'(NTAPS - 1)) begin
          state_d = StDrain;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        accum   = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accum) begin
      acc_d       = acc_valid_q ? acc_q + ACC_W'(prod) : ACC_W'(prod);
      acc_valid_d = 1'b1;
    end

`ifdef ADPCM_FILTEZ_ROUND_EN
    acc_rnd = acc_d + ACC_W'(round_const(SHIFT));
`else
    acc_rnd = acc_d;
`endif
    acc_shr = acc_rnd >>> SHIFT;

    // Result is captured on the final accumulate so it is valid alongside ap_done.
    if (state_q == StDrain) begin
      ret_d = OUT_W'(acc_shr);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      ret_q       <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      ret_q       <= ret_d;
    end
  end

  assign ap_idle      = (state_q == StIdle);
  assign ap_done      = (state_q == StDone);
  assign ap_ready     = ap_done;
  assign bpl_ce0      = (state_q == StRun);
  assign dlt_ce0      = (state_q == StRun);
  assign bpl_address0 = k_q;
  assign dlt_address0 = k_q;
  assign ap_return    = ret_q;

endmodule

// File: tb/tb_adpcm_filtez_mac.sv
// Directed self-checking bench for adpcm_filtez_mac with a 1-cycle-latency memory model.
module tb_adpcm_filtez_mac;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [2:0]  bpl_address0;
  logic        bpl_ce0;
  logic [15:0] bpl_q0;
  logic [2:0]  dlt_address0;
  logic        dlt_ce0;
  logic [15:0] dlt_q0;
  logic [31:0] ap_return;

  logic [15:0] bpl_mem [8];
  logic [15:0] dlt_mem [8];
  logic [2:0]  addr_log [32];

  int checks;
  int passed;

  adpcm_filtez_mac dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .bpl_address0(bpl_address0),
    .bpl_ce0     (bpl_ce0),
    .bpl_q0      (bpl_q0),
    .dlt_address0(dlt_address0),
    .dlt_ce0     (dlt_ce0),
    .dlt_q0      (dlt_q0),
    .ap_return   (ap_return)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    if (bpl_ce0) bpl_q0 <= bpl_mem[bpl_address0];
    if (dlt_ce0) dlt_q0 <= dlt_mem[dlt_address0];
  end

  task automatic set_vec(input logic [15:0] b0, input logic [15:0] bn,
                         input logic [15:0] d0, input logic [15:0] dn);
    for (int i = 0; i < 8; i++) begin
      bpl_mem[i] = (i == 0) ? b0 : ((i < 6) ? bn : 16'h0);
      dlt_mem[i] = (i == 0) ? d0 : ((i < 6) ? dn : 16'h0);
    end
  endtask

  // Start in cycle 0, observe cycles 1..20; bit c of each mask marks activity in cycle c.
  task automatic run_op(input bit hold, output logic [31:0] done_m, output logic [31:0] ready_m,
                        output logic [31:0] ce_m, output logic [31:0] idle_low_m);
    done_m = '0; ready_m = '0; ce_m = '0; idle_low_m = '0;
    @(negedge ap_clk);
    ap_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge ap_clk);
      #1;
      if (!hold || c == 17) ap_start = 1'b0;
      done_m[c]     = ap_done;
      ready_m[c]    = ap_ready;
      ce_m[c]       = bpl_ce0 & dlt_ce0;
      idle_low_m[c] = ~ap_idle;
      addr_log[c]   = bpl_address0;
    end
  endtask

  task automatic check_ret(input string name, input logic [31:0] exp);
    checks++;
    if (ap_return !== exp) $display("FAIL %s: ap_return got %0d required %0d", name,
                                    $signed(ap_return), $signed(exp));
    else passed++;
  endtask

  task automatic test_reset;
    ap_rst = 1'b1;
    ap_start = 1'b0;
    #2;
    checks++;
    if ({ap_done, ap_ready, ap_idle, bpl_ce0, dlt_ce0} !== 5'b00100)
      $display("FAIL reset_ctrl: got %b required 00100",
               {ap_done, ap_ready, ap_idle, bpl_ce0, dlt_ce0});
    else passed++;
    checks++;
    if ({bpl_address0, dlt_address0, ap_return} !== 38'h0)
      $display("FAIL reset_data: got %h required 0", {bpl_address0, dlt_address0, ap_return});
    else passed++;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] dm, rm, cm, im;
    int bad;
    set_vec(16'd1, 16'd1, 16'd16384, 16'd16384);
    run_op(1'b0, dm, rm, cm, im);
    check_ret("basic_result", 32'd6);
    checks++;
    if (dm !== 32'h0000_0100) $display("FAIL basic_done: mask got %h required %h", dm, 32'h100);
    else passed++;
    checks++;
    if (rm !== 32'h0000_0100) $display("FAIL basic_ready: mask got %h required %h", rm, 32'h100);
    else passed++;
    checks++;
    if (cm !== 32'h0000_007E) $display("FAIL basic_ce: mask got %h required %h", cm, 32'h7E);
    else passed++;
    checks++;
    if (im !== 32'h0000_01FE) $display("FAIL basic_idle: mask got %h required %h", im, 32'h1FE);
    else passed++;
    bad = 0;
    for (int c = 1; c <= 6; c++) if (addr_log[c] !== 3'(c - 1)) bad++;
    checks++;
    if (bad != 0) $display("FAIL basic_addr: %0d wrong addresses, required 0", bad);
    else passed++;
  endtask

  task automatic test_negative;
    logic [31:0] dm, rm, cm, im;
    set_vec(16'hFFFF, 16'hFFFF, 16'd16384, 16'd16384);
    run_op(1'b0, dm, rm, cm, im);
    check_ret("negative", 32'hFFFF_FFFA);
  endtask

  task automatic test_rounding;
    logic [31:0] dm, rm, cm, im;
    logic [31:0] exp_pos, exp_neg;
`ifdef ADPCM_FILTEZ_ROUND_EN
    exp_pos = 32'd1;
    exp_neg = 32'd0;
`else
    exp_pos = 32'd0;
    exp_neg = 32'hFFFF_FFFF;
`endif
    set_vec(16'd1, 16'd0, 16'd8192, 16'd0);
    run_op(1'b0, dm, rm, cm, im);
    check_ret("round_pos_half", exp_pos);
    set_vec(16'd1, 16'd0, 16'hE000, 16'd0);
    run_op(1'b0, dm, rm, cm, im);
    check_ret("round_neg_half", exp_neg);
  endtask

  task automatic test_max;
    logic [31:0] dm, rm, cm, im;
    set_vec(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_op(1'b0, dm, rm, cm, im);
    check_ret("max_magnitude", 32'd393216);
  endtask

  task automatic test_reset_abort;
    logic [31:0] dm, rm, cm, im;
    int spurious;
    set_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    @(negedge ap_clk);
    ap_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
    end
    ap_rst = 1'b1;
    #1;
    checks++;
    if ({ap_done, ap_ready, ap_idle, bpl_ce0, dlt_ce0} !== 5'b00100)
      $display("FAIL abort_ctrl: got %b required 00100",
               {ap_done, ap_ready, ap_idle, bpl_ce0, dlt_ce0});
    else passed++;
    checks++;
    if ({bpl_address0, dlt_address0, ap_return} !== 38'h0)
      $display("FAIL abort_data: got %h required 0", {bpl_address0, dlt_address0, ap_return});
    else passed++;
    spurious = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge ap_clk);
      #1;
      if (ap_done) spurious++;
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge ap_clk);
      #1;
      if (ap_done) spurious++;
    end
    checks++;
    if (spurious != 0) $display("FAIL abort_no_done: got %0d done pulses required 0", spurious);
    else passed++;
    set_vec(16'd1, 16'd1, 16'd16384, 16'd16384);
    run_op(1'b0, dm, rm, cm, im);
    check_ret("abort_restart", 32'd6);
    checks++;
    if (dm !== 32'h0000_0100) $display("FAIL abort_done: mask got %h required %h", dm, 32'h100);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] dm, rm, cm, im;
    // Distinct result first so a stale value would be caught.
    set_vec(16'hFFFF, 16'hFFFF, 16'd16384, 16'd16384);
    run_op(1'b0, dm, rm, cm, im);
    set_vec(16'd1, 16'd1, 16'd16384, 16'd16384);
    run_op(1'b1, dm, rm, cm, im);
    checks++;
    if (dm !== 32'h0002_0100) $display("FAIL b2b_done: mask got %h required %h", dm, 32'h20100);
    else passed++;
    checks++;
    if (cm !== 32'h0000_FC7E) $display("FAIL b2b_ce: mask got %h required %h", cm, 32'hFC7E);
    else passed++;
    check_ret("b2b_result", 32'd6);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    ap_rst = 1'b1;
    ap_start = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_rounding();
    test_max();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
